// File: rtl/fp_add_ctrl.sv
// fp_add_ctrl: sequencing controller for the floating-point add/sub/mult datapath.
// Drives alignment selects, the ALU operation and a one-position-per-step
// normalization loop, then reports completion with a single-cycle done pulse.
module fp_add_ctrl #(
    parameter int MAX_NORM_STEPS = 26,
    parameter int MAX_ALIGN      = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op_in,
    input  logic [7:0]  expDiff,
    input  logic [26:0] fracResult,
    input  logic        carry,
    output logic        smallerExpSrc,
    output logic [7:0]  shiftRightQtt,
    output logic [1:0]  operation,
    output logic        normalization_src,
    output logic        shift_src,
    output logic        shift,
    output logic        busy,
    output logic        done,
    output logic        zero,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        EXEC,
        NORM_EVAL,
        NORM_WAIT,
        DONE
    } state_t;

    localparam int          CNT_W       = $clog2(MAX_NORM_STEPS + 1);
    localparam logic [8:0]  MAX_ALIGN_W = 9'(MAX_ALIGN);
    localparam logic [CNT_W-1:0] MAX_STEPS_W = CNT_W'(MAX_NORM_STEPS);
    localparam logic [1:0]  OP_MULT     = 2'b10;
    localparam logic [1:0]  OP_ILLEGAL  = 2'b11;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             smaller_exp_src_q, smaller_exp_src_d;
    logic [7:0]       shift_right_qtt_q, shift_right_qtt_d;
    logic [1:0]       operation_q, operation_d;
    logic             norm_src_q, norm_src_d;
    logic             shift_src_q, shift_src_d;
    logic             shift_q, shift_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic [8:0]       abs_diff;
    logic [7:0]       align_amt;

    // Magnitude of the exponent difference, widened so that -128 is representable, then saturated.
    always_comb begin
        abs_diff  = expDiff[7] ? ({1'b0, ~expDiff} + 9'd1) : {1'b0, expDiff};
        align_amt = (abs_diff > MAX_ALIGN_W) ? MAX_ALIGN_W[7:0] : abs_diff[7:0];
    end

    // Next-state and registered-output computation for the sequencing FSM.
    always_comb begin
        state_d           = state_q;
        step_cnt_d        = step_cnt_q;
        smaller_exp_src_d = smaller_exp_src_q;
        shift_right_qtt_d = shift_right_qtt_q;
        operation_d       = operation_q;
        norm_src_d        = norm_src_q;
        shift_src_d       = shift_src_q;
        shift_d           = 1'b0;
        busy_d            = busy_q;
        done_d            = 1'b0;
        zero_d            = zero_q;
        err_d             = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    operation_d = op_in;
                    busy_d      = 1'b1;
                    zero_d      = 1'b0;
                    err_d       = 1'b0;
                    step_cnt_d  = '0;
                    state_d     = ALIGN;
                    if (op_in != OP_ILLEGAL) begin
                        norm_src_d = 1'b1;
                    end
                end
            end
            ALIGN: begin
                if (operation_q == OP_ILLEGAL) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    if (operation_q == OP_MULT) begin
                        smaller_exp_src_d = 1'b1;
                        shift_right_qtt_d = 8'd0;
                    end else begin
                        smaller_exp_src_d = ~expDiff[7];
                        shift_right_qtt_d = align_amt;
                    end
                    norm_src_d = 1'b1;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                state_d = NORM_EVAL;
            end
            NORM_EVAL: begin
                if ((step_cnt_q == '0) && carry) begin
                    shift_d     = 1'b1;
                    shift_src_d = 1'b1;
                    step_cnt_d  = step_cnt_q + CNT_W'(1);
                    state_d     = NORM_WAIT;
                end else if (fracResult == 27'd0) begin
                    zero_d  = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else if (fracResult[26]) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else if (step_cnt_q == MAX_STEPS_W) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    shift_d     = 1'b1;
                    shift_src_d = 1'b0;
                    step_cnt_d  = step_cnt_q + CNT_W'(1);
                    state_d     = NORM_WAIT;
                end
            end
            NORM_WAIT: begin
                norm_src_d = 1'b0;
                state_d    = NORM_EVAL;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            step_cnt_q        <= '0;
            smaller_exp_src_q <= 1'b0;
            shift_right_qtt_q <= 8'd0;
            operation_q       <= 2'b00;
            norm_src_q        <= 1'b0;
            shift_src_q       <= 1'b0;
            shift_q           <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            zero_q            <= 1'b0;
            err_q             <= 1'b0;
        end else begin
            state_q           <= state_d;
            step_cnt_q        <= step_cnt_d;
            smaller_exp_src_q <= smaller_exp_src_d;
            shift_right_qtt_q <= shift_right_qtt_d;
            operation_q       <= operation_d;
            norm_src_q        <= norm_src_d;
            shift_src_q       <= shift_src_d;
            shift_q           <= shift_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            zero_q            <= zero_d;
            err_q             <= err_d;
        end
    end

    assign smallerExpSrc     = smaller_exp_src_q;
    assign shiftRightQtt     = shift_right_qtt_q;
    assign operation         = operation_q;
    assign normalization_src = norm_src_q;
    assign shift_src         = shift_src_q;
    assign shift             = shift_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign zero              = zero_q;
    assign err               = err_q;

endmodule

// File: tb/tb_fp_add_ctrl.sv
// tb_fp_add_ctrl: directed bench for fp_add_ctrl with a small datapath model
// that reacts to normalization shift strobes.
module tb_fp_add_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op_in;
    logic [7:0]  expDiff;
    logic [26:0] fracResult;
    logic        carry;
    logic        smallerExpSrc;
    logic [7:0]  shiftRightQtt;
    logic [1:0]  operation;
    logic        normalization_src;
    logic        shift_src;
    logic        shift;
    logic        busy;
    logic        done;
    logic        zero;
    logic        err;

    int checks = 0;
    int errors = 0;

    int   cyc;
    int   done_cyc;
    int   pulses;
    int   right_pulses;
    int   left_pulses;
    int   done_count;
    logic consec;
    logic prev_shift;
    logic norm_at_first;
    logic norm_at_done;
    logic busy_at_first;
    logic busy_at_done;
    logic zero_at_done;
    logic err_at_done;
    logic ses_at_done;
    logic [7:0] srq_at_done;
    logic [1:0] op_at_done;

    fp_add_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .op_in             (op_in),
        .expDiff           (expDiff),
        .fracResult        (fracResult),
        .carry             (carry),
        .smallerExpSrc     (smallerExpSrc),
        .shiftRightQtt     (shiftRightQtt),
        .operation         (operation),
        .normalization_src (normalization_src),
        .shift_src         (shift_src),
        .shift             (shift),
        .busy              (busy),
        .done              (done),
        .zero              (zero),
        .err               (err)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Runs one operation from an IDLE cycle to its done pulse, modelling the
    // datapath shifter (frozen mode keeps the fraction unchanged).
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] ed,
                                 input logic [26:0] fr, input logic cy, input bit freeze);
        stepCycle();
        op_in      = op;
        expDiff    = ed;
        fracResult = fr;
        carry      = cy;
        start      = 1'b1;
        stepCycle();
        start         = 1'b0;
        cyc           = 1;
        done_cyc      = 0;
        pulses        = 0;
        right_pulses  = 0;
        left_pulses   = 0;
        consec        = 1'b0;
        prev_shift    = 1'b0;
        norm_at_first = 1'b0;
        busy_at_first = busy;
        for (int i = 0; i < 80 && done_cyc == 0; i++) begin
            if (shift && prev_shift) consec = 1'b1;
            prev_shift = shift;
            if (shift) begin
                pulses++;
                if (shift_src) right_pulses++;
                else left_pulses++;
                if (pulses == 1) norm_at_first = normalization_src;
                if (!freeze) begin
                    fracResult = shift_src ? {carry, fracResult[26:1]} : {fracResult[25:0], 1'b0};
                end
            end
            if (done) begin
                done_cyc     = cyc;
                norm_at_done = normalization_src;
                busy_at_done = busy;
                zero_at_done = zero;
                err_at_done  = err;
                ses_at_done  = smallerExpSrc;
                srq_at_done  = shiftRightQtt;
                op_at_done   = operation;
            end else begin
                stepCycle();
                cyc++;
            end
        end
    endtask

    // Directed sequence of operations with hand-computed expectations.
    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        op_in      = 2'b00;
        expDiff    = 8'h00;
        fracResult = 27'd0;
        carry      = 1'b0;
        repeat (3) stepCycle();
        checkOutput("reset_outputs", 32'({smallerExpSrc, shiftRightQtt, operation, normalization_src,
                                          shift_src, shift, busy, done, zero, err}), 32'd0);
        reset = 1'b0;

        $display("[TB] add, aligned result");
        applyStimulus(2'b00, 8'h03, 27'h4000000, 1'b0, 1'b0);
        checkOutput("add_done_cycle", 32'(done_cyc), 32'd4);
        checkOutput("add_ses", 32'(ses_at_done), 32'd1);
        checkOutput("add_srq", 32'(srq_at_done), 32'd3);
        checkOutput("add_pulses", 32'(pulses), 32'd0);
        checkOutput("add_zero_err", 32'({zero_at_done, err_at_done}), 32'd0);
        checkOutput("add_norm_src", 32'(norm_at_done), 32'd1);
        checkOutput("add_busy", 32'({busy_at_first, busy_at_done}), 32'b10);

        $display("[TB] add with carry");
        applyStimulus(2'b00, 8'hFB, 27'h0000000, 1'b1, 1'b0);
        checkOutput("carry_done_cycle", 32'(done_cyc), 32'd6);
        checkOutput("carry_ses", 32'(ses_at_done), 32'd0);
        checkOutput("carry_srq", 32'(srq_at_done), 32'd5);
        checkOutput("carry_right_pulses", 32'(right_pulses), 32'd1);
        checkOutput("carry_total_pulses", 32'(pulses), 32'd1);
        checkOutput("carry_norm_src", 32'({norm_at_first, norm_at_done}), 32'b10);
        checkOutput("carry_zero_err", 32'({zero_at_done, err_at_done}), 32'd0);

        $display("[TB] sub needing left shifts");
        applyStimulus(2'b01, 8'h00, 27'h0800000, 1'b0, 1'b0);
        checkOutput("sub_done_cycle", 32'(done_cyc), 32'd10);
        checkOutput("sub_left_pulses", 32'(left_pulses), 32'd3);
        checkOutput("sub_right_pulses", 32'(right_pulses), 32'd0);
        checkOutput("sub_no_consec", 32'(consec), 32'd0);
        checkOutput("sub_ses_srq", 32'({ses_at_done, srq_at_done}), 32'h100);
        checkOutput("sub_operation", 32'(op_at_done), 32'd1);

        $display("[TB] zero result");
        applyStimulus(2'b00, 8'h10, 27'h0000000, 1'b0, 1'b0);
        checkOutput("zero_done_cycle", 32'(done_cyc), 32'd4);
        checkOutput("zero_flag", 32'({zero_at_done, err_at_done}), 32'b10);
        checkOutput("zero_pulses", 32'(pulses), 32'd0);
        checkOutput("zero_srq", 32'(srq_at_done), 32'd16);

        $display("[TB] mult ignores exponent difference");
        applyStimulus(2'b10, 8'hF0, 27'h4000000, 1'b0, 1'b0);
        checkOutput("mult_ses_srq", 32'({ses_at_done, srq_at_done}), 32'h100);
        checkOutput("mult_operation", 32'(op_at_done), 32'd2);

        $display("[TB] full-length normalization");
        applyStimulus(2'b00, 8'h01, 27'h0000001, 1'b0, 1'b0);
        checkOutput("long_done_cycle", 32'(done_cyc), 32'd56);
        checkOutput("long_pulses", 32'(left_pulses), 32'd26);
        checkOutput("long_err", 32'(err_at_done), 32'd0);

        $display("[TB] step limit");
        applyStimulus(2'b01, 8'h01, 27'h0000001, 1'b0, 1'b1);
        checkOutput("limit_done_cycle", 32'(done_cyc), 32'd56);
        checkOutput("limit_pulses", 32'(pulses), 32'd26);
        checkOutput("limit_err", 32'({zero_at_done, err_at_done}), 32'b01);
        checkOutput("limit_no_consec", 32'(consec), 32'd0);

        $display("[TB] alignment saturation");
        applyStimulus(2'b00, 8'h80, 27'h4000000, 1'b0, 1'b0);
        checkOutput("sat_srq", 32'(srq_at_done), 32'd27);
        checkOutput("sat_ses", 32'(ses_at_done), 32'd0);
        checkOutput("sat_done_cycle", 32'(done_cyc), 32'd4);

        $display("[TB] illegal op");
        applyStimulus(2'b11, 8'h05, 27'h4000000, 1'b0, 1'b0);
        checkOutput("illegal_done_cycle", 32'(done_cyc), 32'd2);
        checkOutput("illegal_err", 32'(err_at_done), 32'd1);
        checkOutput("illegal_holds_align", 32'({ses_at_done, srq_at_done}), 32'h01B);
        checkOutput("illegal_operation", 32'(op_at_done), 32'd3);

        $display("[TB] reset during NORM_WAIT");
        stepCycle();
        op_in      = 2'b01;
        expDiff    = 8'h02;
        fracResult = 27'h0800000;
        carry      = 1'b0;
        start      = 1'b1;
        stepCycle();
        start = 1'b0;
        repeat (3) stepCycle();
        checkOutput("reset_mid_shift_seen", 32'(shift), 32'd1);
        reset = 1'b1;
        stepCycle();
        checkOutput("reset_mid_outputs", 32'({smallerExpSrc, shiftRightQtt, operation, normalization_src,
                                              shift_src, shift, busy, done, zero, err}), 32'd0);
        reset      = 1'b0;
        done_count = 0;
        for (int i = 0; i < 12; i++) begin
            stepCycle();
            if (done) done_count++;
        end
        checkOutput("reset_no_done", 32'(done_count), 32'd0);

        $display("[TB] start while busy");
        op_in      = 2'b00;
        expDiff    = 8'h01;
        fracResult = 27'h4000000;
        start      = 1'b1;
        stepCycle();
        cyc        = 1;
        done_count = 0;
        done_cyc   = 0;
        for (int i = 0; i < 20; i++) begin
            start = (cyc == 2 || cyc == 3);
            if (done) begin
                done_count++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            stepCycle();
            cyc++;
        end
        start = 1'b0;
        checkOutput("busy_single_done", 32'(done_count), 32'd1);
        checkOutput("busy_done_cycle", 32'(done_cyc), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
